frame_splitter: RTL and testbench

//  Splits a strobed byte stream into two streams: the fast-word group and the slow-word group of each frame.
//  - iData is captured on each rising edge of an asynchronous strobe.
//  - Per frame: first F_LEN words go to the fast port, next S_LEN words go to the slow port.
//  - Adds what the fixed 16+2 splitter lacked: parametrised widths/lengths, word index outputs,

---
 rtl/frame_splitter_pkg.sv | 28 ++
 rtl/frame_splitter_edge_sync.sv | 30 +++
 rtl/frame_splitter.sv | 106 ++++++++++
 tb/tb_frame_splitter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_splitter_pkg.sv
// Shared defaults, routing type and helper functions for the frame splitter slice.
// Imported by the splitter top and reusable by neighbouring telemetry blocks.
package frame_splitter_pkg;

    localparam int unsigned DEF_DW       = 8;
    localparam int unsigned DEF_F_LEN    = 16;
    localparam int unsigned DEF_S_LEN    = 2;
    localparam int unsigned DEF_SYNC_STG = 2;
    localparam int unsigned DEF_ERR_W    = 8;

    typedef enum logic {
        ROUTE_FAST = 1'b0,
        ROUTE_SLOW = 1'b1
    } route_e;

    // Width of a counter covering 0..f_len+s_len-1 (never below 1 bit).
    function automatic int unsigned cnt_width(input int unsigned f_len, input int unsigned s_len);
        return (f_len + s_len > 1) ? $clog2(f_len + s_len) : 1;
    endfunction

    // Saturating increment of a w-bit value carried in 32 bits (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/frame_splitter_edge_sync.sv
// Multi-stage synchroniser for an asynchronous strobe with a registered single-cycle
// edge pulse; RISE selects rising (1) or falling (0) edge detection.
module edge_sync #(
    parameter int unsigned SYNC_STG = 2,
    parameter bit          RISE     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic pulse
);

    logic [SYNC_STG-1:0] sync;
    logic                newer;
    logic                older;

    assign newer = sync[SYNC_STG-2];
    assign older = sync[SYNC_STG-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STG-2:0], sig};
            pulse <= RISE ? (newer & ~older) : (~newer & older);
        end
    end

endmodule

// File: rtl/frame_splitter.sv
// Splits a strobed word stream into per-frame fast and slow groups, with word indices,
// frame resync, frame-done pulse and a saturating frame-error counter.
module frame_splitter
    import frame_splitter_pkg::*;
#(
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned F_LEN    = DEF_F_LEN,
    parameter int unsigned S_LEN    = DEF_S_LEN,
    parameter int unsigned SYNC_STG = DEF_SYNC_STG,
    parameter int unsigned ERR_W    = DEF_ERR_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DW-1:0]                       iData,
    input  logic                                strob,
    input  logic                                frmSync,
    output logic [DW-1:0]                       fData,
    output logic [cnt_width(F_LEN, S_LEN)-1:0]  fIdx,
    output logic                                fVal,
    output logic [DW-1:0]                       sData,
    output logic [cnt_width(F_LEN, S_LEN)-1:0]  sIdx,
    output logic                                sVal,
    output logic                                frmDone,
    output logic                                frmErr,
    output logic [ERR_W-1:0]                    errCnt
);

    localparam int unsigned   CW      = cnt_width(F_LEN, S_LEN);
    localparam logic [CW-1:0] LAST    = CW'(F_LEN + S_LEN - 1);
    localparam logic [CW-1:0] F_START = CW'(F_LEN);

    logic          word_edge;
    logic [CW-1:0] cnt;
    logic [CW-1:0] slot;
    logic          wrap_keep;
    route_e        route;

    edge_sync #(
        .SYNC_STG (SYNC_STG),
        .RISE     (1'b1)
    ) u_strob_sync (
        .clk   (clk),
        .rst   (rst),
        .sig   (strob),
        .pulse (word_edge)
    );

    // A resync normally makes the current word word 0, except on the last word of a
    // frame, which still completes that frame (the wrap lands on 0 anyway).
    always_comb begin
        wrap_keep = word_edge && (cnt == LAST);
        slot      = (frmSync && !wrap_keep) ? '0 : cnt;
        route     = (slot < F_START) ? ROUTE_FAST : ROUTE_SLOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            fData   <= '0;
            fIdx    <= '0;
            fVal    <= 1'b0;
            sData   <= '0;
            sIdx    <= '0;
            sVal    <= 1'b0;
            frmDone <= 1'b0;
        end else begin
            fVal    <= 1'b0;
            sVal    <= 1'b0;
            frmDone <= 1'b0;
            if (word_edge) begin
                if (route == ROUTE_FAST) begin
                    fData <= iData;
                    fIdx  <= slot;
                    fVal  <= 1'b1;
                end else begin
                    sData <= iData;
                    sIdx  <= slot - F_START;
                    sVal  <= 1'b1;
                end
                if (slot == LAST) begin
                    cnt     <= '0;
                    frmDone <= 1'b1;
                end else begin
                    cnt <= slot + CW'(1);
                end
            end else if (frmSync) begin
                cnt <= '0;
            end
        end
    end

    // Error judged on the counter value before this cycle's resync or word.
    always_ff @(posedge clk) begin
        if (rst) begin
            frmErr <= 1'b0;
            errCnt <= '0;
        end else begin
            frmErr <= 1'b0;
            if (frmSync && (cnt != '0)) begin
                frmErr <= 1'b1;
                errCnt <= ERR_W'(sat_inc(32'(errCnt), ERR_W));
            end
        end
    end

endmodule

// File: tb/tb_frame_splitter.sv
// Directed scoreboard bench for frame_splitter: default-parameter instance plus a
// F_LEN=4/S_LEN=3/DW=12 instance, expected words queued at stimulus time.
module tb_frame_splitter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // default instance
    logic [7:0] d_data = '0;
    logic       d_strob = 1'b0;
    logic       d_sync = 1'b0;
    logic [7:0] d_fData, d_sData, d_errCnt;
    logic [4:0] d_fIdx, d_sIdx;
    logic       d_fVal, d_sVal, d_done, d_err;

    // small-frame instance
    logic [11:0] e_data = '0;
    logic        e_strob = 1'b0;
    logic        e_sync = 1'b0;
    logic [11:0] e_fData, e_sData;
    logic [7:0]  e_errCnt;
    logic [2:0]  e_fIdx, e_sIdx;
    logic        e_fVal, e_sVal, e_done, e_err;

    frame_splitter #(.DW(8), .F_LEN(16), .S_LEN(2), .SYNC_STG(2), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .iData(d_data), .strob(d_strob), .frmSync(d_sync),
        .fData(d_fData), .fIdx(d_fIdx), .fVal(d_fVal),
        .sData(d_sData), .sIdx(d_sIdx), .sVal(d_sVal),
        .frmDone(d_done), .frmErr(d_err), .errCnt(d_errCnt)
    );

    frame_splitter #(.DW(12), .F_LEN(4), .S_LEN(3), .SYNC_STG(2), .ERR_W(8)) dut6 (
        .clk(clk), .rst(rst), .iData(e_data), .strob(e_strob), .frmSync(e_sync),
        .fData(e_fData), .fIdx(e_fIdx), .fVal(e_fVal),
        .sData(e_sData), .sIdx(e_sIdx), .sVal(e_sVal),
        .frmDone(e_done), .frmErr(e_err), .errCnt(e_errCnt)
    );

    typedef struct {
        bit          slow;
        logic [31:0] data;
        int unsigned idx;
        bit          done;
    } exp_t;

    exp_t q_d[$];
    exp_t q_e[$];

    int total = 0;
    int bad = 0;
    int unsigned mc_d = 0, mc_e = 0;
    int unsigned merr_d = 0;
    int unsigned err_seen_d = 0, done_seen_d = 0, done_seen_e = 0;
    time rise_d = 0, rise_e = 0, val_t_d = 0, val_t_e = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat8(input int unsigned n);
        return (n > 255) ? 32'd255 : 32'(n);
    endfunction

    task automatic model_word(input bit six, input logic [31:0] d, input bit sync);
        int unsigned fl, sl, last, c;
        exp_t e;
        fl   = six ? 4 : 16;
        sl   = six ? 3 : 2;
        last = fl + sl - 1;
        c    = six ? mc_e : mc_d;
        if (sync) begin
            if (c != 0) merr_d++;
            if (c != last) c = 0;
        end
        e.slow = (c >= fl);
        e.idx  = e.slow ? c - fl : c;
        e.data = d;
        e.done = (c == last);
        c      = e.done ? 0 : c + 1;
        if (six) begin mc_e = c; q_e.push_back(e); end
        else begin mc_d = c; q_d.push_back(e); end
    endtask

    // Relaxed-spacing word; optional frmSync in the DUT's edge cycle.
    task automatic send(input bit six, input logic [11:0] d, input bit sync);
        @(negedge clk);
        if (six) begin
            model_word(1'b1, 32'(d), 1'b0);
            e_data = d; e_strob = 1'b1; rise_e = $time;
        end else begin
            model_word(1'b0, 32'(d[7:0]), sync);
            d_data = d[7:0]; d_strob = 1'b1; rise_d = $time;
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        if (sync) d_sync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_sync = 1'b0; d_strob = 1'b0; e_strob = 1'b0;
        @(posedge clk);
        @(posedge clk);
    endtask

    // Minimum spacing: edges SYNC_STG+1 cycles apart.
    task automatic send_fast(input logic [7:0] d);
        @(negedge clk);
        model_word(1'b0, 32'(d), 1'b0);
        d_data = d; d_strob = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        d_strob = 1'b0;
        @(posedge clk);
    endtask

    task automatic pulse_sync();
        @(negedge clk);
        if (mc_d != 0) merr_d++;
        mc_d = 0;
        d_sync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_sync = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (d_err) err_seen_d++;
            check("d_excl", 32'(d_fVal & d_sVal), 0);
            if (d_fVal || d_sVal) begin
                val_t_d = $time;
                if (d_done) done_seen_d++;
                check("d_q_nonempty", 32'(q_d.size() != 0), 1);
                if (q_d.size() != 0) begin
                    e = q_d.pop_front();
                    check("d_route", 32'(d_sVal), 32'(e.slow));
                    check("d_data", e.slow ? 32'(d_sData) : 32'(d_fData), e.data);
                    check("d_idx", e.slow ? 32'(d_sIdx) : 32'(d_fIdx), 32'(e.idx));
                    check("d_done", 32'(d_done), 32'(e.done));
                end
            end else begin
                check("d_done_idle", 32'(d_done), 0);
            end
            check("e_excl", 32'(e_fVal & e_sVal), 0);
            if (e_fVal || e_sVal) begin
                val_t_e = $time;
                if (e_done) done_seen_e++;
                check("e_q_nonempty", 32'(q_e.size() != 0), 1);
                if (q_e.size() != 0) begin
                    e = q_e.pop_front();
                    check("e_route", 32'(e_sVal), 32'(e.slow));
                    check("e_data", e.slow ? 32'(e_sData) : 32'(e_fData), e.data);
                    check("e_idx", e.slow ? 32'(e_sIdx) : 32'(e_fIdx), 32'(e.idx));
                    check("e_done", 32'(e_done), 32'(e.done));
                end
            end else begin
                check("e_done_idle", 32'(e_done), 0);
            end
            check("e_err_none", 32'(e_err), 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned dn;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_fData", 32'(d_fData), 0);
        check("rst_fIdx", 32'(d_fIdx), 0);
        check("rst_sData", 32'(d_sData), 0);
        check("rst_vals", 32'({d_fVal, d_sVal, d_done, d_err}), 0);
        check("rst_errCnt", 32'(d_errCnt), 0);
        check("rst_e_out", 32'({e_fData, e_sData, e_fIdx, e_sIdx}), 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: one full default frame
        for (int i = 0; i < 18; i++) begin
            send(1'b0, 12'(32'h10 + i), 1'b0);
            if (i == 0) check("lat_d", 32'((val_t_d - 1 + 5 - rise_d) / 10), 3);
        end
        check("t1_done", 32'(done_seen_d), 1);
        check("t1_sData", 32'(d_sData), 32'h21);
        check("t1_sIdx", 32'(d_sIdx), 1);
        check("t1_fData", 32'(d_fData), 32'h1F);
        check("t1_errCnt", 32'(d_errCnt), 0);

        // 2: two frames at minimum strobe spacing
        dn = done_seen_d;
        for (int i = 0; i < 36; i++) send_fast(8'(8'h40 + (i % 18)));
        repeat (4) @(posedge clk);
        check("t2_done", 32'(done_seen_d - dn), 2);
        check("t2_err", 32'(err_seen_d), 0);

        // 3: short frame cut by frmSync
        for (int i = 0; i < 5; i++) send(1'b0, 12'(32'h50 + i), 1'b0);
        pulse_sync();
        @(posedge clk);
        #2;
        check("t3_err_seen", 32'(err_seen_d), 1);
        check("t3_errCnt", 32'(d_errCnt), 1);
        send(1'b0, 12'hAA, 1'b0);
        check("t3_fIdx", 32'(d_fIdx), 0);
        check("t3_fData", 32'(d_fData), 32'hAA);

        // 4: frmSync coincident with the edge of word 7
        for (int i = 0; i < 6; i++) send(1'b0, 12'(32'h60 + i), 1'b0);
        send(1'b0, 12'h77, 1'b1);
        check("t4_fIdx", 32'(d_fIdx), 0);
        check("t4_fData", 32'(d_fData), 32'h77);
        check("t4_errCnt", 32'(d_errCnt), 2);
        check("t4_err_seen", 32'(err_seen_d), 2);

        // frmSync on the wrapping word: frame completes and error flagged
        dn = done_seen_d;
        for (int i = 0; i < 16; i++) send(1'b0, 12'(32'h80 + i), 1'b0);
        send(1'b0, 12'h99, 1'b1);
        check("wrap_done", 32'(done_seen_d - dn), 1);
        check("wrap_sIdx", 32'(d_sIdx), 1);
        check("wrap_errCnt", 32'(d_errCnt), 3);

        // 6: small frame instance
        for (int i = 0; i < 7; i++) begin
            send(1'b1, 12'(32'h100 + i), 1'b0);
            if (i == 0) check("lat_e", 32'((val_t_e - 1 + 5 - rise_e) / 10), 3);
        end
        check("t6_done", 32'(done_seen_e), 1);
        check("t6_fIdx", 32'(e_fIdx), 3);
        check("t6_sIdx", 32'(e_sIdx), 2);
        check("t6_sData", 32'(e_sData), 32'h106);

        // 5: saturate errCnt, then reset mid-frame
        for (int i = 0; i < 300; i++) begin
            send(1'b0, 12'(i & 8'hFF), 1'b0);
            pulse_sync();
        end
        @(posedge clk);
        #2;
        check("t5_errCnt", 32'(d_errCnt), sat8(merr_d));
        check("t5_err_seen", 32'(err_seen_d), 32'(merr_d));
        for (int i = 0; i < 3; i++) send(1'b0, 12'(32'hC0 + i), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_f", 32'({d_fData, d_fIdx, d_fVal}), 0);
        check("mid_rst_s", 32'({d_sData, d_sIdx, d_sVal}), 0);
        check("mid_rst_e", 32'({d_done, d_err, d_errCnt}), 0);
        @(negedge clk);
        rst = 1'b0;
        mc_d = 0;
        mc_e = 0;
        send(1'b0, 12'h3C, 1'b0);
        check("post_rst_fIdx", 32'(d_fIdx), 0);
        check("post_rst_errCnt", 32'(d_errCnt), 0);

        repeat (4) @(posedge clk);
        #2;
        check("q_d_empty", 32'(q_d.size()), 0);
        check("q_e_empty", 32'(q_e.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
